uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Next-generation UART transmitter: configurable frame (data bits, parity, stop bits), internal
//  baud generator and a small transmit FIFO with valid/ready push handshake. Sits between the
//  sensor formatter (DHT11 readout -> ASCII) and the board TX pin; one frame per FIFO entry.
// PARAMETERS
//  CLK_FREQ    1_000_000  system clock in Hz
//  BAUD        100_000    line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer, >= 4)
//  DATA_BITS   8          5..9 data bits per frame, LSB first
//  PARITY      0          0 none, 1 odd, 2 even (uart_pkg constants)
//  STOP_BITS   1          1 or 2
//  FIFO_DEPTH  4          power of two, >= 2
// PORTS
//  clk       in   1  system clock, rising edge
//  rst       in   1  asynchronous, active-high reset
//  tx_valid  in   1  push request; word accepted on clk edge where tx_valid && tx_ready
//  tx_data   in   9  frame data; only [DATA_BITS-1:0] used, upper bits ignored
//  tx_ready  out  1  FIFO not full (registered)
//  tx        out  1  serial line, idle high
//  tx_done   out  1  one-clk pulse at end of each frame's last stop bit
//  tx_busy   out  1  high while a frame is on the line or FIFO non-empty
//  tx_break  in   1  only with UART_TX_BREAK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): tx=1, tx_ready=1, tx_done=0, tx_busy=0, FIFO emptied, FSM=IDLE, baud cnt=0.
//   Reset mid-frame aborts the frame at once; tx returns high asynchronously; no tx_done.
//  FSM: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//   IDLE: if FIFO non-empty, pop into shift reg, go START. START: tx=0 for DIV clks.
//   DATA: DATA_BITS bits LSB first, DIV clks each. PARITY: odd/even over the DATA_BITS bits.
//   STOP: tx=1 for STOP_BITS*DIV clks; on last clk tx_done=1, go IDLE (back-to-back if non-empty).
//  Latency: word accepted at edge N -> tx falls after edge N+2 (empty FIFO, idle FSM).
//  Baud counter counts 0..DIV-1, cleared on entry to START; bit boundaries frame-aligned.
//  Frame length exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV clks; back-to-back frames
//   have zero idle gap.
//  FIFO: push when full ignored (tx_ready=0); tx_ready from registered count, so a push in the
//   same cycle as a pop from a full FIFO is refused. Simultaneous push+pop otherwise keeps count.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  tx_busy = (FSM!=IDLE) | (count!=0); low again the cycle after tx_done if FIFO empty.
//  tx is a registered output (glitch-free).
// CONFIGURATION
//  UART_TX_BREAK_EN defined: tx_break port exists. tx_break sampled in IDLE only (a request
//   mid-frame waits for end of current frame); while high, FSM in BREAK, tx=0, no pops,
//   tx_busy=1. On deassert, tx=1 for one full bit time (DIV clks) before the next frame.
//  Not defined: port absent, BREAK state not built; tx never low outside START/data/parity 0s.
// STRUCTURE
//  uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding (incl. BREAK), clog2 function.
//  Sub-module uart_tx_fifo (DEPTH, WIDTH=9; push/pop/full/empty/count), instanced once.
//  Baud counter, shift reg, bit counter and FSM live in uart_tx_cfg.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10)
//  8N1, push 0x41 -> tx: 0 | 1,0,0,0,0,0,1,0 | 1, 10 clks each; tx_done 100 clks after start edge.
//  8E1 push 0x5A / 8O2 push 0x5A -> parity bit 0 / 1; frame 110 / 120 clks; stop high 10 / 20.
//  Push 6 words with DEPTH=4 while idle -> 5 accepted (1 popped + 4 held), 6th sees tx_ready=0;
//   5 frames back-to-back, no idle gap, 5 tx_done pulses.
//  DATA_BITS=7, push 9'h1C1 -> only 7'h41 sent; frame 90 clks (8N... 7N1).
//  rst pulse at data bit 3 -> tx=1 immediately, tx_busy=0, tx_ready=1, no tx_done; next push
//   sends clean frame.
//  UART_TX_BREAK_EN: tx_break high 50 clks mid-frame with 0x55 queued -> frame completes, tx=0
//   50 clks, tx=1 >= 10 clks, then 0x55 sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and helpers for the configurable UART transmitter.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak,
      StBreakGap
   } tx_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with registered occupancy count; pushes while full are dropped.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [clog2(DEPTH):0]      count
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full     = (count_q == (AW + 1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: frame FSM, baud counter and FIFO front end.
// Define UART_TX_BREAK_EN to build the tx_break port and line-break states.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 1_000_000,
   parameter int unsigned BAUD       = 100_000,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = PARITY_NONE,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [8:0] tx_data,
`ifdef UART_TX_BREAK_EN
   input  logic       tx_break,
`endif
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_done,
   output logic       tx_busy
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = clog2(DIV);
   localparam logic [8:0] DATA_MASK = 9'((1 << DATA_BITS) - 1);

   tx_state_e           state_q, state_d;
   logic [CW-1:0]       baud_q, baud_d;
   logic [3:0]          bit_q, bit_d;
   logic [8:0]          shift_q, shift_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                pop, fifo_full, fifo_empty;
   logic [8:0]          fifo_data;
   logic [clog2(FIFO_DEPTH):0] fifo_count;
   logic                baud_last, brk_req, start_ok, frame_parity, par_even;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef UART_TX_BREAK_EN
   assign brk_req = tx_break;
`else
   assign brk_req = 1'b0;
`endif

   assign tx_ready     = !fifo_full;
   assign baud_last    = (baud_q == CW'(DIV - 1));
   assign start_ok     = !fifo_empty && !brk_req;
   assign par_even     = ^(fifo_data & DATA_MASK);
   assign frame_parity = (PARITY == PARITY_ODD) ? ~par_even : par_even;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            baud_d = '0;
            if (brk_req) begin
               state_d = StBreak;
            end else if (start_ok) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               par_d   = frame_parity;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_last) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (baud_last) begin
               state_d = StStop;
               bit_d   = '0;
            end
         end
         StStop: begin
            if (baud_last) begin
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  // Chain straight into the next start bit so frames abut.
                  if (start_ok) begin
                     pop     = 1'b1;
                     shift_d = fifo_data;
                     par_d   = frame_parity;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         StBreak: begin
            baud_d = '0;
            if (!brk_req) state_d = StBreakGap;
         end
         StBreakGap: begin
            if (baud_last) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Line level follows the registered state, giving one clock of latency.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_q[0];
         StParity: tx_d = par_q;
`ifdef UART_TX_BREAK_EN
         StBreak:  tx_d = 1'b0;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_q != StIdle) || (fifo_count != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four frame formats (8N1, 8E1, 8O2, 7N1) against a bit-time line model.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   localparam int DIV = 10;
   localparam int LOG = 8192;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] valid = '0;
   logic [8:0] data [4];
   logic [3:0] ready, txl, done, busy;
`ifdef UART_TX_BREAK_EN
   logic       brk = 1'b0;
`endif

   int nb_c  [4] = '{8, 8, 8, 7};
   int par_c [4] = '{0, 2, 1, 0};
   int sb_c  [4] = '{1, 1, 2, 1};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic log_tx   [4][LOG];
   logic log_done [4][LOG];
   logic log_busy [4][LOG];

   always #5 clk = ~clk;

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0]),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk),
`endif
      .tx_ready(ready[0]), .tx(txl[0]), .tx_done(done[0]), .tx_busy(busy[0]));
   uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1]),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk),
`endif
      .tx_ready(ready[1]), .tx(txl[1]), .tx_done(done[1]), .tx_busy(busy[1]));
   uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
      .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2]),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk),
`endif
      .tx_ready(ready[2]), .tx(txl[2]), .tx_done(done[2]), .tx_busy(busy[2]));
   uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
      .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data[3]),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk),
`endif
      .tx_ready(ready[3]), .tx(txl[3]), .tx_done(done[3]), .tx_busy(busy[3]));

   // Log index i holds the outputs seen after the i-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (cyc < LOG) begin
         for (int k = 0; k < 4; k++) begin
            log_tx[k][cyc]   = txl[k];
            log_done[k][cyc] = done[k];
            log_busy[k][cyc] = busy[k];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int frame_len(input int k);
      return (1 + nb_c[k] + ((par_c[k] != 0) ? 1 : 0) + sb_c[k]) * DIV;
   endfunction

   // Expected line level t clocks into a frame, from the frame layout alone.
   function automatic logic exp_tx(input int k, input logic [8:0] w, input int t);
      int   b;
      logic p;
      b = t / DIV;
      if (b == 0) return 1'b0;
      if (b <= nb_c[k]) return w[b-1];
      if (par_c[k] != 0 && b == nb_c[k] + 1) begin
         p = 1'b0;
         for (int i = 0; i < nb_c[k]; i++) p = p ^ w[i];
         return (par_c[k] == 1) ? ~p : p;
      end
      return 1'b1;
   endfunction

   task automatic wait_cyc(input int target);
      while (cyc <= target) @(negedge clk);
   endtask

   task automatic push(input int k, input logic [8:0] w, output int a);
      @(negedge clk);
      valid[k] = 1'b1;
      data[k]  = w;
      a = cyc;
      @(negedge clk);
      valid[k] = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks += 4;
         if (txl[k] !== 1'b1) begin
            failures++; $display("FAIL reset_tx[%0d]: got %b expected 1", k, txl[k]);
         end
         if (ready[k] !== 1'b1) begin
            failures++; $display("FAIL reset_ready[%0d]: got %b expected 1", k, ready[k]);
         end
         if (done[k] !== 1'b0) begin
            failures++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done[k]);
         end
         if (busy[k] !== 1'b0) begin
            failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Single frame from an empty FIFO: start bit expected three log slots after the push slot.
   task automatic test_frame(input int k, input logic [8:0] w);
      int a, s0, len, errs, derrs;
      push(k, w, a);
      s0  = a + 3;
      len = frame_len(k);
      wait_cyc(s0 + len + 2);
      errs = 0;
      for (int t = 0; t < len; t++) if (log_tx[k][s0+t] !== exp_tx(k, w, t)) errs++;
      derrs = 0;
      for (int i = a + 1; i <= s0 + len; i++)
         if (log_done[k][i] !== ((i == s0 + len - 1) ? 1'b1 : 1'b0)) derrs++;
      checks += 5;
      if (log_tx[k][s0-1] !== 1'b1) begin
         failures++; $display("FAIL latency[%0d] w=%h: tx before start %b expected 1", k, w, log_tx[k][s0-1]);
      end
      if (errs != 0) begin
         failures++; $display("FAIL waveform[%0d] w=%h: %0d bad clocks expected 0", k, w, errs);
      end
      if (derrs != 0) begin
         failures++; $display("FAIL done_pulse[%0d] w=%h: %0d bad clocks expected 0", k, w, derrs);
      end
      if (log_busy[k][s0] !== 1'b1) begin
         failures++; $display("FAIL busy_mid[%0d]: got %b expected 1", k, log_busy[k][s0]);
      end
      if (log_busy[k][s0+len] !== 1'b0 || log_tx[k][s0+len] !== 1'b1) begin
         failures++; $display("FAIL after_frame[%0d]: busy %b tx %b expected 0 1", k,
                              log_busy[k][s0+len], log_tx[k][s0+len]);
      end
   endtask

   task automatic test_formats();
      logic [8:0] spec_w [4] = '{9'h041, 9'h05A, 9'h05A, 9'h1C1};
      for (int k = 0; k < 4; k++) begin
         test_frame(k, spec_w[k]);
         for (int r = 0; r < 2; r++) test_frame(k, 9'($urandom_range(0, 511)));
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] w [6];
      int a, s0, len, errs, derrs;
      logic exp_rdy;
      len = frame_len(0);
      for (int i = 0; i < 6; i++) w[i] = 9'($urandom_range(0, 511));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) a = cyc;
         exp_rdy = (i < 5);
         checks++;
         if (ready[0] !== exp_rdy) begin
            failures++; $display("FAIL b2b_ready push%0d: got %b expected %b", i, ready[0], exp_rdy);
         end
         valid[0] = 1'b1;
         data[0]  = w[i];
      end
      @(negedge clk);
      valid[0] = 1'b0;
      s0 = a + 3;
      wait_cyc(s0 + 5 * len + 2);
      errs = 0;
      derrs = 0;
      for (int f = 0; f < 5; f++)
         for (int t = 0; t < len; t++)
            if (log_tx[0][s0 + f*len + t] !== exp_tx(0, w[f], t)) errs++;
      for (int i = s0; i <= s0 + 5 * len; i++)
         if (log_done[0][i] !== ((i >= s0 + len - 1 && i < s0 + 5 * len &&
                                  ((i - s0 + 1) % len) == 0) ? 1'b1 : 1'b0)) derrs++;
      checks += 3;
      if (errs != 0) begin
         failures++; $display("FAIL b2b_waveform: %0d bad clocks expected 0", errs);
      end
      if (derrs != 0) begin
         failures++; $display("FAIL b2b_done: %0d bad clocks expected 0", derrs);
      end
      if (log_busy[0][s0 + 5 * len] !== 1'b0) begin
         failures++; $display("FAIL b2b_busy_end: got %b expected 0", log_busy[0][s0 + 5 * len]);
      end
   endtask

   task automatic test_reset_midframe();
      int a, s0, stop_at, dcount;
      push(0, 9'($urandom_range(0, 255)), a);
      s0 = a + 3;
      wait_cyc(s0 + 4 * DIV + 4);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if (txl[0] !== 1'b1) begin
         failures++; $display("FAIL midrst_tx: got %b expected 1", txl[0]);
      end
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
         failures++; $display("FAIL midrst_busy_done: got %b %b expected 0 0", busy[0], done[0]);
      end
      if (ready[0] !== 1'b1) begin
         failures++; $display("FAIL midrst_ready: got %b expected 1", ready[0]);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stop_at = cyc + 120;
      wait_cyc(stop_at);
      dcount = 0;
      for (int i = s0; i <= stop_at; i++) if (log_done[0][i] === 1'b1) dcount++;
      checks++;
      if (dcount != 0) begin
         failures++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dcount);
      end
      test_frame(0, 9'($urandom_range(0, 511)));
   endtask

   initial begin
      for (int k = 0; k < 4; k++) data[k] = '0;
      test_reset();
      test_formats();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
